// File: rtl/i2c_reg_slave_pkg.sv
// Shared types and constants for the I2C register target: FSM states, default address, ACK levels.
package i2c_reg_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR_HI,
        ST_ACK_HI,
        ST_PTR_LO,
        ST_ACK_LO,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_MACK,
        ST_WAIT
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h36;
    localparam logic       ACK              = 1'b0;
    localparam logic       NACK             = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain: 2-flop sync, FILT_LEN-sample glitch filter, and
// single-cycle SCL edge and START/STOP strobes derived from the filtered levels.
module i2c_bus_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // Index 0 carries SCL, index 1 carries SDA; an idle bus is high on both.
    logic [1:0]          meta_q;
    logic [1:0]          sync_q;
    logic [1:0]          filt_q;
    logic [1:0]          filt_d;
    logic [1:0]          accept;
    logic [FILT_LEN-1:0] hist_q [2];

    always_comb begin
        accept = '0;
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            accept[i] = ((hist_q[i] == '1) && !filt_q[i]) || ((hist_q[i] == '0) && filt_q[i]);
            if (accept[i]) begin
                filt_d[i] = ~filt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q    <= '1;
            sync_q    <= '1;
            filt_q    <= '1;
            hist_q[0] <= '1;
            hist_q[1] <= '1;
        end else begin
            meta_q    <= {sda_i, scl_i};
            sync_q    <= meta_q;
            hist_q[0] <= (hist_q[0] << 1) | FILT_LEN'(sync_q[0]);
            hist_q[1] <= (hist_q[1] << 1) | FILT_LEN'(sync_q[1]);
            filt_q    <= filt_d;
        end
    end

    // An SDA transition only counts as START/STOP while SCL is steadily high.
    assign sda_o      = filt_q[1];
    assign scl_rise_o = accept[0] & ~filt_q[0];
    assign scl_fall_o = accept[0] &  filt_q[0];
    assign start_o    = accept[1] &  filt_q[1] & filt_q[0] & ~accept[0];
    assign stop_o     = accept[1] & ~filt_q[1] & filt_q[0] & ~accept[0];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register target: 7-bit address, 16-bit auto-incrementing pointer, 8-bit registers,
// open-drain SDA. Bits are sampled on SCL rise; SDA only changes after SCL fall.
module i2c_reg_slave
    import i2c_reg_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         NUM_REGS = 256,
    parameter int         FILT_LEN = 3
) (
    input  logic clk,
    input  logic rstn,
    inout  wire  scl,
    inout  wire  sda
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic sda_lvl, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.FILT_LEN(FILT_LEN)) u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .scl_i     (scl),
        .sda_i     (sda),
        .sda_o     (sda_lvl),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [15:0] ptr_q;
    logic       rw_q;
    logic       sda_oe_q;
    logic [7:0] regs_q [NUM_REGS];

    logic [IDX_W-1:0] idx;
    logic [7:0]       rd_byte;

    assign idx     = ptr_q[IDX_W-1:0];
    assign rd_byte = regs_q[idx];
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (stop) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
        end else if (start) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_ADDR, ST_PTR_HI, ST_PTR_LO, ST_WDATA: begin
                    shift_q   <= {shift_q[6:0], sda_lvl};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                ST_RDATA: bit_cnt_q <= bit_cnt_q + 4'd1;
                ST_MACK: if (sda_lvl == NACK) state_q <= ST_WAIT;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_q <= '0;
                    if (shift_q[7:1] == DEV_ADDR) begin
                        rw_q     <= shift_q[0];
                        sda_oe_q <= 1'b1;
                        state_q  <= ST_ACK_ADDR;
                    end else begin
                        state_q  <= ST_WAIT;
                    end
                end
                ST_PTR_HI: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_q   <= '0;
                    ptr_q[15:8] <= shift_q;
                    sda_oe_q    <= 1'b1;
                    state_q     <= ST_ACK_HI;
                end
                ST_PTR_LO: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_q  <= '0;
                    ptr_q[7:0] <= shift_q;
                    sda_oe_q   <= 1'b1;
                    state_q    <= ST_ACK_LO;
                end
                ST_WDATA: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_q   <= '0;
                    regs_q[idx] <= shift_q;
                    ptr_q       <= ptr_q + 16'd1;
                    sda_oe_q    <= 1'b1;
                    state_q     <= ST_ACK_W;
                end
                // The fall ending an ACK slot releases SDA, or presents a read byte's MSB.
                ST_ACK_ADDR, ST_MACK: begin
                    if (rw_q) begin
                        shift_q  <= rd_byte;
                        sda_oe_q <= ~rd_byte[7];
                        state_q  <= ST_RDATA;
                    end else begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_PTR_HI;
                    end
                end
                ST_ACK_HI: begin
                    sda_oe_q <= 1'b0;
                    state_q  <= ST_PTR_LO;
                end
                ST_ACK_LO, ST_ACK_W: begin
                    sda_oe_q <= 1'b0;
                    state_q  <= ST_WDATA;
                end
                ST_RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_q <= '0;
                        sda_oe_q  <= 1'b0;
                        ptr_q     <= ptr_q + 16'd1;
                        state_q   <= ST_MACK;
                    end else if (bit_cnt_q != 4'd0) begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_oe_q  <= ~shift_q[6];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: a bit-banged open-drain master with hand-computed
// expected ACKs and read data.
module tb_i2c_reg_slave;
    import i2c_reg_slave_pkg::*;

    localparam int Q = 100;

    logic clk = 1'b0;
    logic rstn;
    logic scl_drv;
    logic sda_drv;
    wire  scl;
    wire  sda;
    int   n_cmp = 0;
    int   n_fail = 0;

    assign scl = scl_drv;
    assign sda = sda_drv ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_reg_slave dut (
        .clk (clk),
        .rstn(rstn),
        .scl (scl),
        .sda (sda)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_drv = b;    #Q;
        scl_drv = 1'b1; #Q;
        r = sda;        #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic start_cond();
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #Q;
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b1; #Q;
        sda_drv = 1'b1; #Q;
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, r);
        check(tag, {7'd0, r == ACK}, {7'd0, exp_ack});
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp, input logic last);
        logic r;
        logic [7:0] d;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(last ? NACK : ACK, r);
        check(tag, d, exp);
    endtask

    task automatic wr_regs(input string tag, input logic [15:0] ptr,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int n);
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        start_cond();
        write_byte({tag, "_adr"}, 8'h6C, 1'b1);
        write_byte({tag, "_phi"}, ptr[15:8], 1'b1);
        write_byte({tag, "_plo"}, ptr[7:0], 1'b1);
        for (int i = 0; i < n; i++) write_byte($sformatf("%s_w%0d", tag, i), d[i], 1'b1);
        stop_cond();
    endtask

    task automatic rd_regs(input string tag, input logic set_ptr, input logic [15:0] ptr,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input int n);
        logic [7:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        start_cond();
        if (set_ptr) begin
            write_byte({tag, "_wadr"}, 8'h6C, 1'b1);
            write_byte({tag, "_phi"}, ptr[15:8], 1'b1);
            write_byte({tag, "_plo"}, ptr[7:0], 1'b1);
            start_cond();
        end
        write_byte({tag, "_radr"}, 8'h6D, 1'b1);
        for (int i = 0; i < n; i++) read_byte($sformatf("%s_r%0d", tag, i), e[i], i == n - 1);
        stop_cond();
    endtask

    initial begin
        logic r;
        logic [7:0] addr_w;
        logic [3:0] nib;

        rstn = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
        #(2 * Q);
        rstn = 1'b1;
        #(2 * Q);

        // Reset state: bus released, pointer 0, registers cleared.
        check("rst_sda", {7'd0, sda}, 8'h01);
        rd_regs("rst_rd", 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 1);

        // 1: single write at 0x3008 (aliases index 0x08), read back via repeated START.
        wr_regs("t1w", 16'h3008, 8'h5A, 8'h00, 8'h00, 1);
        rd_regs("t1r", 1'b1, 16'h3008, 8'h5A, 8'h00, 8'h00, 1);

        // 2: seed index 0x03, burst write at 0x0100, burst read, then current-address read.
        wr_regs("t2s", 16'h0003, 8'h77, 8'h00, 8'h00, 1);
        wr_regs("t2w", 16'h0100, 8'h11, 8'h22, 8'h33, 3);
        rd_regs("t2r", 1'b1, 16'h0100, 8'h11, 8'h22, 8'h33, 3);
        rd_regs("t2c", 1'b0, 16'h0000, 8'h77, 8'h00, 8'h00, 1);

        // 3: foreign address is never ACKed and following bytes are ignored.
        start_cond();
        write_byte("t3_adr", 8'h6E, 1'b0);
        write_byte("t3_phi", 8'h00, 1'b0);
        write_byte("t3_plo", 8'h08, 1'b0);
        write_byte("t3_dat", 8'h99, 1'b0);
        stop_cond();
        rd_regs("t3r", 1'b1, 16'h0008, 8'h5A, 8'h00, 8'h00, 1);

        // 4: pointer wrap from 0xFFFF; pointer ends at 0x0001 (holding 0x22).
        wr_regs("t4w", 16'hFFFF, 8'hAA, 8'hBB, 8'h00, 2);
        rd_regs("t4c", 1'b0, 16'h0000, 8'h22, 8'h00, 8'h00, 1);
        rd_regs("t4r", 1'b1, 16'h00FF, 8'hAA, 8'hBB, 8'h00, 2);

        // 5: STOP after 4 data bits discards the partial byte.
        start_cond();
        write_byte("t5_adr", 8'h6C, 1'b1);
        write_byte("t5_phi", 8'h00, 1'b1);
        write_byte("t5_plo", 8'h10, 1'b1);
        nib = 4'hF;
        for (int i = 3; i >= 0; i--) clock_bit(nib[i], r);
        stop_cond();
        rd_regs("t5r", 1'b1, 16'h0010, 8'h00, 8'h00, 8'h00, 1);
        wr_regs("t5w", 16'h0010, 8'hC3, 8'h00, 8'h00, 1);
        rd_regs("t5v", 1'b1, 16'h0010, 8'hC3, 8'h00, 8'h00, 1);

        // 6: reset while the target drives ACK releases SDA at once.
        start_cond();
        addr_w = 8'h6C;
        for (int i = 7; i >= 0; i--) clock_bit(addr_w[i], r);
        sda_drv = 1'b1;
        check("t6_ack_drv", {7'd0, sda}, 8'h00);
        rstn = 1'b0;
        #1;
        check("t6_rst_rel", {7'd0, sda}, 8'h01);
        #Q;
        rstn = 1'b1;
        #Q;
        stop_cond();
        rd_regs("t6c", 1'b1, 16'h0008, 8'h00, 8'h00, 8'h00, 1);
        wr_regs("t6w", 16'h0042, 8'hE7, 8'h00, 8'h00, 1);
        rd_regs("t6r", 1'b1, 16'h0042, 8'hE7, 8'h00, 8'h00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
